// File: rtl/pipe_issue_if.sv
// Operand/handshake bundle between the issue unit and its driver.
// Ports: load port (ld_*), run control (start/len), issue fields, status.
interface pipe_issue_if;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [23:0] ld_data;
    logic        start;
    logic [8:0]  len;
    logic        issue_valid;
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  addr;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    modport master (
        output ld_en, ld_addr, ld_data, start, len,
        input  issue_valid, func, rd, rs1, rs2, addr,
        input  busy, done, stall_cnt
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, len,
        output issue_valid, func, rd, rs1, rs2, addr,
        output busy, done, stall_cnt
    );
endinterface

// File: rtl/pipe_issue.sv
// Program-buffer issue unit with RAW bubble insertion for a no-forwarding pipe.
// Ports: clk, rst (sync, active high), bus (pipe_issue_if.slave).
module pipe_issue #(
    parameter int DEPTH     = 256,
    parameter int HAZ_WIN   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    pipe_issue_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [23:0]        mem [DEPTH];
    logic [7:0]         pc;
    logic [8:0]         remain;
    logic [7:0]         drain_cnt;
    logic               empty_run;

    logic [HAZ_WIN-1:0] win_v;
    logic [3:0]         win_rd [HAZ_WIN];

    logic               q_valid;
    logic [3:0]         q_func;
    logic [3:0]         q_rd;
    logic [3:0]         q_rs1;
    logic [3:0]         q_rs2;
    logic [7:0]         q_addr;
    logic               q_busy;
    logic               q_done;
    logic [15:0]        q_stall;

    logic [23:0]        cur;
    logic [3:0]         cur_func;
    logic [3:0]         cur_rd;
    logic [3:0]         cur_rs1;
    logic [3:0]         cur_rs2;
    logic [7:0]         cur_addr;
    logic               hazard;
    logic               in_idle;
    logic               start_ok;
    logic               load_ok;
    logic               issue_ok;

    assign in_idle  = (state == S_IDLE);
    assign start_ok = in_idle && bus.start;
    assign load_ok  = in_idle && bus.ld_en;

    // Program buffer: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign cur      = mem[pc];
    assign cur_func = cur[23:20];
    assign cur_rd   = cur[19:16];
    assign cur_rs1  = cur[15:12];
    assign cur_rs2  = cur[11:8];
    assign cur_addr = cur[7:0];

    // Both sources are checked regardless of func; the window only
    // holds older instructions, so rd==rs of the fetched word is ignored.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (win_v[i] &&
                (win_rd[i] == cur_rs1 || win_rd[i] == cur_rs2)) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue_ok = (state == S_ISSUE) && !hazard;

    // Entry 0 mirrors the instruction currently on the outputs.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            win_v <= '0;
            for (int i = 0; i < HAZ_WIN; i++) begin
                win_rd[i] <= 4'd0;
            end
        end else if (state == S_ISSUE || state == S_DRAIN) begin
            for (int i = HAZ_WIN - 1; i > 0; i--) begin
                win_v[i]  <= win_v[i-1];
                win_rd[i] <= win_rd[i-1];
            end
            win_v[0]  <= issue_ok;
            win_rd[0] <= issue_ok ? cur_rd : 4'd0;
        end
    end

    // Operand register: a real word only on a clean issue, else a bubble.
    always_ff @(posedge clk) begin
        if (rst || !issue_ok) begin
            q_valid <= 1'b0;
            q_func  <= 4'd0;
            q_rd    <= 4'd0;
            q_rs1   <= 4'd0;
            q_rs2   <= 4'd0;
            q_addr  <= 8'd0;
        end else begin
            q_valid <= 1'b1;
            q_func  <= cur_func;
            q_rd    <= cur_rd;
            q_rs1   <= cur_rs1;
            q_rs2   <= cur_rs2;
            q_addr  <= cur_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= 8'd0;
            remain    <= 9'd0;
            drain_cnt <= 8'd0;
            empty_run <= 1'b0;
            q_busy    <= 1'b0;
            q_done    <= 1'b0;
            q_stall   <= 16'd0;
        end else begin
            q_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    q_busy <= 1'b0;
                    if (bus.start) begin
                        q_busy    <= 1'b1;
                        q_stall   <= 16'd0;
                        pc        <= 8'd0;
                        remain    <= bus.len;
                        empty_run <= (bus.len == 9'd0);
                        state     <= (bus.len == 9'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hazard) begin
                        if (q_stall != 16'hFFFF) begin
                            q_stall <= q_stall + 16'd1;
                        end
                    end else begin
                        // pc wraps to 0 after entry 255 of a full run.
                        pc     <= pc + 8'd1;
                        remain <= remain - 9'd1;
                        if (remain == 9'd1) begin
                            drain_cnt <= 8'd0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    if (drain_cnt == 8'(DRAIN_CYC - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // An empty run drops busy together with the done pulse;
                    // a real run keeps busy through the done cycle.
                    q_done <= 1'b1;
                    q_busy <= !empty_run;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_valid = q_valid;
    assign bus.func        = q_func;
    assign bus.rd          = q_rd;
    assign bus.rs1         = q_rs1;
    assign bus.rs2         = q_rs2;
    assign bus.addr        = q_addr;
    assign bus.busy        = q_busy;
    assign bus.done        = q_done;
    assign bus.stall_cnt   = q_stall;
endmodule
